// File: rtl/bcd_clock_6d.sv
// bcd_clock_6d: six-digit BCD hh:mm:ss clock with set strobes and a display digit scanner
module bcd_clock_6d #(
  parameter int TICK_DIV = 1000,
  parameter int SCAN_DIV = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_run,
  input  logic       i_set_min,
  input  logic       i_set_hour,
  output logic [3:0] o_dig0,
  output logic [3:0] o_dig1,
  output logic [3:0] o_dig2,
  output logic [3:0] o_dig3,
  output logic [3:0] o_dig4,
  output logic [3:0] o_dig5,
  output logic [2:0] o_sel,
  output logic       o_tick
);
  localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  logic [TW-1:0] tcnt;
  logic [SW-1:0] scnt;
  logic          wrap, swrap, set_any, sec_max, min_max;
  logic [7:0]    sec_inc, min_inc, hour_inc;
  assign wrap    = i_run && tcnt == TW'(TICK_DIV - 1);
  assign swrap   = scnt == SW'(SCAN_DIV - 1);
  assign set_any = i_set_min | i_set_hour;
  // next-value arithmetic for each BCD field, each wrapping within its legal range
  always_comb begin
    sec_max  = o_dig1 == 4'd5 && o_dig0 == 4'd9;
    min_max  = o_dig3 == 4'd5 && o_dig2 == 4'd9;
    sec_inc  = sec_max ? 8'h00 : o_dig0 == 4'd9 ? {o_dig1 + 4'd1, 4'd0} : {o_dig1, o_dig0 + 4'd1};
    min_inc  = min_max ? 8'h00 : o_dig2 == 4'd9 ? {o_dig3 + 4'd1, 4'd0} : {o_dig3, o_dig2 + 4'd1};
    hour_inc = (o_dig5 == 4'd2 && o_dig4 == 4'd3) ? 8'h00 :
               o_dig4 == 4'd9 ? {o_dig5 + 4'd1, 4'd0} : {o_dig5, o_dig4 + 4'd1};
  end
  // time keeping: set strobes override a coincident second tick
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tcnt <= '0;
      o_tick <= 1'b0;
      {o_dig5, o_dig4, o_dig3, o_dig2, o_dig1, o_dig0} <= '0;
    end else begin
      tcnt <= (i_set_min || wrap) ? '0 : i_run ? tcnt + 1'b1 : tcnt;
      o_tick <= wrap && !set_any;
      if (set_any) begin
        if (i_set_min) {o_dig3, o_dig2, o_dig1, o_dig0} <= {min_inc, 8'h00};
        if (i_set_hour) {o_dig5, o_dig4} <= hour_inc;
      end else if (wrap) begin
        {o_dig1, o_dig0} <= sec_inc;
        if (sec_max) {o_dig3, o_dig2} <= min_inc;
        if (sec_max && min_max) {o_dig5, o_dig4} <= hour_inc;
      end
    end
  end
  // free-running digit scanner cycling 0..5
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      scnt <= '0;
      o_sel <= '0;
    end else begin
      scnt <= swrap ? '0 : scnt + 1'b1;
      if (swrap) o_sel <= o_sel == 3'd5 ? 3'd0 : o_sel + 3'd1;
    end
  end
endmodule

// File: tb/tb_bcd_clock_6d.sv
// tb_bcd_clock_6d: randomized and directed checks of bcd_clock_6d against a seconds-based model
module tb_bcd_clock_6d;
  localparam int TD = 4;
  localparam int SD = 2;
  logic clk = 1'b0, rst = 1'b0, run = 1'b0, smin = 1'b0, shour = 1'b0;
  logic [3:0] d0, d1, d2, d3, d4, d5, e0, e1, e2, e3, e4, e5;
  logic [2:0] sel, sel1;
  logic tick, tick1;
  int n_checks = 0, n_errors = 0;
  int h, m, s, pc, sc, msel, msel1, mtick;
  always #5 clk = ~clk;
  bcd_clock_6d #(.TICK_DIV(TD), .SCAN_DIV(SD)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_set_min(smin), .i_set_hour(shour),
    .o_dig0(d0), .o_dig1(d1), .o_dig2(d2), .o_dig3(d3), .o_dig4(d4), .o_dig5(d5),
    .o_sel(sel), .o_tick(tick));
  bcd_clock_6d #(.TICK_DIV(2), .SCAN_DIV(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_run(run), .i_set_min(smin), .i_set_hour(shour),
    .o_dig0(e0), .o_dig1(e1), .o_dig2(e2), .o_dig3(e3), .o_dig4(e4), .o_dig5(e5),
    .o_sel(sel1), .o_tick(tick1));
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int bcd(input int hh, input int mm, input int ss);
    return ((hh / 10) << 20) | ((hh % 10) << 16) | ((mm / 10) << 12) | ((mm % 10) << 8) |
           ((ss / 10) << 4) | (ss % 10);
  endfunction
  function automatic int digits();
    return int'({d5, d4, d3, d2, d1, d0});
  endfunction
  task automatic model_reset();
    h = 0; m = 0; s = 0; pc = 0; sc = 0; msel = 0; msel1 = 0; mtick = 0;
  endtask
  task automatic compare();
    check("time", digits(), bcd(h, m, s));
    check("tick", int'(tick), mtick);
    check("sel", int'(sel), msel);
    check("sel_range", int'(sel < 3'd6), 1);
    check("sel1", int'(sel1), msel1);
  endtask
  task automatic step(input logic r, input logic sm, input logic sh);
    int t;
    logic w;
    run = r; smin = sm; shour = sh;
    @(posedge clk);
    w = r && pc == TD - 1;
    mtick = (w && !sm && !sh) ? 1 : 0;
    pc = (sm || w) ? 0 : r ? pc + 1 : pc;
    if (sm) begin m = (m + 1) % 60; s = 0; end
    if (sh) h = (h + 1) % 24;
    if (mtick == 1) begin
      t = (h * 3600 + m * 60 + s + 1) % 86400;
      h = t / 3600; m = (t / 60) % 60; s = t % 60;
    end
    if (sc == SD - 1) begin sc = 0; msel = (msel + 1) % 6; end else sc++;
    msel1 = (msel1 + 1) % 6;
    #1 compare();
    smin = 1'b0; shour = 1'b0;
  endtask
  initial begin
    model_reset();
    #2 rst = 1'b1;
    #1 check("rst_time", digits(), 0);
    check("rst_tick", int'(tick), 0);
    check("rst_sel", int'(sel), 0);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 40; i++) step(1, 0, 0);
    check("run40_time", digits(), bcd(0, 0, 10));
    check("run40_d1", int'(d1), 1);
    check("run40_d0", int'(d0), 0);
    for (int i = 0; i < 23; i++) step(0, 0, 1);
    for (int i = 0; i < 59; i++) step(0, 1, 0);
    check("preset_2359", digits(), bcd(23, 59, 0));
    for (int i = 0; i < 240; i++) step(1, 0, 0);
    check("rollover_time", digits(), 0);
    check("rollover_tick", int'(tick), 1);
    for (int i = 0; i < 12; i++) step(0, 0, 1);
    for (int i = 0; i < 34; i++) step(0, 1, 0);
    for (int i = 0; i < 224; i++) step(1, 0, 0);
    check("at_123456", digits(), bcd(12, 34, 56));
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    step(1, 1, 0);
    check("setmin_wrap_time", digits(), bcd(12, 35, 0));
    check("setmin_wrap_tick", int'(tick), 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    check("after_set_no_tick", int'(tick), 0);
    step(1, 0, 0);
    check("after_set_tick", int'(tick), 1);
    check("after_set_time", digits(), bcd(12, 35, 1));
    for (int i = 0; i < 11; i++) step(0, 0, 1);
    for (int i = 0; i < 100; i++) step(0, 0, i == 50);
    check("frozen_hours", int'({d5, d4}), 0);
    check("frozen_secs", int'({d1, d0}), 1);
    step(1, 0, 0);
    step(1, 0, 0);
    #2 rst = 1'b1;
    #1 check("async_rst_time", digits(), 0);
    check("async_rst_tick", int'(tick), 0);
    check("async_rst_sel", int'(sel), 0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < TD - 1; i++) step(1, 0, 0);
    check("post_rst_no_tick", int'(tick), 0);
    step(1, 0, 0);
    check("post_rst_tick", int'(tick), 1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
